vga_sync_controller: RTL and testbench

Generates 640x480@60 VGA raster timing. Drives `pixelX`/`pixelY` to the drawing blocks and receives their registered packed 8-bit colour back. Expands that colour to 24-bit RGB, aligns it with delayed sync/blank, and registers it to the DAC pins. It is the consumer end of the pixel-coordinate/colour interface used by every `*_draw` block.

---
 rtl/vga_sync_controller.sv | 172 +++++++++++++++++
 tb/tb_vga_sync_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_controller.sv
// vga_sync_controller: 640x480@60 raster counters, sync/blank generation, colour expansion and DAC output stage.
// Defining VGA_TEST_PATTERN_EN builds an internal colour-bar source selected by testPattern.
`timescale 1ns/1ps
module vga_sync_controller #(
    parameter int PIPE_DELAY = 1,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    input  logic        testPattern,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB
);

    localparam logic [10:0] H_LAST       = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST       = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);

    // r_running holds the counters at (0,0) for the first edge after reset release,
    // so (0,0) is presented for one full cycle before counting starts.
    logic        r_running;
    logic [10:0] r_pixel_x;
    logic [10:0] r_pixel_y;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_running <= 1'b0;
            r_pixel_x <= '0;
            r_pixel_y <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge value of the others.
            r_running <= 1'b1;
            if (r_running) begin
                if (r_pixel_x == H_LAST) begin
                    r_pixel_x <= '0;
                    r_pixel_y <= (r_pixel_y == V_LAST) ? 11'd0 : r_pixel_y + 11'd1;
                end else begin
                    r_pixel_x <= r_pixel_x + 11'd1;
                end
            end
        end
    end

    assign pixelX       = r_pixel_x;
    assign pixelY       = r_pixel_y;
    assign startOfFrame = r_running && (r_pixel_x == 11'd0) && (r_pixel_y == 11'd0);

    logic w_hs_raw;
    logic w_vs_raw;
    logic w_active_raw;

    assign w_hs_raw     = !(r_running && (r_pixel_x >= H_SYNC_START) && (r_pixel_x < H_SYNC_END));
    assign w_vs_raw     = !(r_running && (r_pixel_y >= V_SYNC_START) && (r_pixel_y < V_SYNC_END));
    assign w_active_raw = r_running && (r_pixel_x < H_VIS) && (r_pixel_y < V_VIS);

    // Timing delay line: the last stage lines up with the drawer's RGBIn for the same coordinate.
    logic [PIPE_DELAY-1:0] r_hs_dly;
    logic [PIPE_DELAY-1:0] r_vs_dly;
    logic [PIPE_DELAY-1:0] r_act_dly;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hs_dly  <= '1;
            r_vs_dly  <= '1;
            r_act_dly <= '0;
        end else begin
            r_hs_dly[0]  <= w_hs_raw;
            r_vs_dly[0]  <= w_vs_raw;
            r_act_dly[0] <= w_active_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_hs_dly[i]  <= r_hs_dly[i-1];
                r_vs_dly[i]  <= r_vs_dly[i-1];
                r_act_dly[i] <= r_act_dly[i-1];
            end
        end
    end

    logic [7:0] w_pixel;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] r_bar_dly [PIPE_DELAY];
    logic [2:0] w_bar_k;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: this array is a short shift register, not a RAM, so resetting every entry is cheap and keeps it deterministic.
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_bar_dly[i] <= '0;
            end
        end else begin
            r_bar_dly[0] <= r_pixel_x[8:6];
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_bar_dly[i] <= r_bar_dly[i-1];
            end
        end
    end

    assign w_bar_k = r_bar_dly[PIPE_DELAY-1];
    assign w_pixel = testPattern ? {{2{w_bar_k[0]}}, {3{w_bar_k[1]}}, {3{w_bar_k[2]}}} : RGBIn;
`else
    logic w_unused_test_pattern;

    assign w_unused_test_pattern = testPattern;
    assign w_pixel               = RGBIn;
`endif

    logic [1:0] w_b;
    logic [2:0] w_r;
    logic [2:0] w_g;

    assign {w_b, w_r, w_g} = w_pixel;

    logic       r_vga_hs;
    logic       r_vga_vs;
    logic       r_vga_blank_n;
    logic [7:0] r_vga_r;
    logic [7:0] r_vga_g;
    logic [7:0] r_vga_b;

    // Sync, blank and colour share one register stage so they reach the DAC on the same edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_vga_blank_n <= 1'b0;
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
        end else begin
            r_vga_hs      <= r_hs_dly[PIPE_DELAY-1];
            r_vga_vs      <= r_vs_dly[PIPE_DELAY-1];
            r_vga_blank_n <= r_act_dly[PIPE_DELAY-1];
            if (r_act_dly[PIPE_DELAY-1]) begin
                r_vga_r <= {w_r, w_r, w_r[2:1]};
                r_vga_g <= {w_g, w_g, w_g[2:1]};
                r_vga_b <= {w_b, w_b, w_b, w_b};
            end else begin
                r_vga_r <= '0;
                r_vga_g <= '0;
                r_vga_b <= '0;
            end
        end
    end

    assign vgaHS     = r_vga_hs;
    assign vgaVS     = r_vga_vs;
    assign vgaBlankN = r_vga_blank_n;
    assign vgaR      = r_vga_r;
    assign vgaG      = r_vga_g;
    assign vgaB      = r_vga_b;

endmodule

// File: tb/tb_vga_sync_controller.sv
// tb_vga_sync_controller: drives vga_sync_controller with directed and random colour streams and
// compares every output, every cycle, against an arithmetic raster model (short vertical frame).
`timescale 1ns/1ps
module tb_vga_sync_controller;

    localparam int PD = 1;
    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit PATTERN_BUILT = 1'b1;
`else
    localparam bit PATTERN_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  RGBIn = 8'h00;
    logic        testPattern = 1'b0;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, vgaHS, vgaVS, vgaBlankN;
    logic [7:0]  vgaR, vgaG, vgaB;

    always #20 clk = ~clk;

    vga_sync_controller #(
        .PIPE_DELAY(PD),
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .testPattern(testPattern),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .vgaHS(vgaHS), .vgaVS(vgaVS), .vgaBlankN(vgaBlankN),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
    );

    typedef enum int { M_RANDOM, M_RAMP, M_CONST } mode_e;
    typedef struct { int x; int y; logic [23:0] rgb; logic blank_n; } spot_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc;
    mode_e      mode = M_RANDOM;
    logic [7:0] const_val = 8'h00;
    logic       tp_value = 1'b0;
    logic       tp_rand = 1'b0;
    logic [7:0] rgb_hist [16];
    logic       tp_hist  [16];
    spot_t      spots[$];
    int         spot_hits;
    int         hs_low, vs_low, blank_high, last_sof;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Raster rules: where cycle c of a frame sits and what its raw sync/active are.
    function automatic void raw_at(input int c, output logic hs, output logic vs, output logic act);
        int x, y;
        if (c < 0) begin
            hs = 1'b1; vs = 1'b1; act = 1'b0;
            return;
        end
        x = c % HT;
        y = (c / HT) % VT;
        hs  = !(x >= HV + HF && x < HV + HF + HS);
        vs  = !(y >= VV + VF && y < VV + VF + VS);
        act = (x < HV) && (y < VV);
    endfunction

    // 3/2-bit components scaled to 0..255 with rounding.
    function automatic logic [23:0] expand(input logic [7:0] p);
        int b, r, g;
        b = int'(p[7:6]);
        r = int'(p[5:3]);
        g = int'(p[2:0]);
        return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
    endfunction

    function automatic logic [23:0] bars(input int x);
        int k;
        k = (x / 64) % 8;
        return {((k / 2) % 2 == 1) ? 8'hFF : 8'h00,
                ((k / 4) % 2 == 1) ? 8'hFF : 8'h00,
                (k % 2 == 1)       ? 8'hFF : 8'h00};
    endfunction

    task automatic check_reset_values();
        check("rst_pixelX", 32'(pixelX), 0);
        check("rst_pixelY", 32'(pixelY), 0);
        check("rst_sof", 32'(startOfFrame), 0);
        check("rst_hs", 32'(vgaHS), 1);
        check("rst_vs", 32'(vgaVS), 1);
        check("rst_blank", 32'(vgaBlankN), 0);
        check("rst_rgb", 32'({vgaR, vgaG, vgaB}), 0);
    endtask

    task automatic monitor_clear();
        hs_low = 0; vs_low = 0; blank_high = 0; last_sof = -1;
    endtask

    task automatic check_cycle();
        int src, ci;
        logic hs, vs, act;
        logic [23:0] rgb;
        src = cyc - PD - 1;
        raw_at(src, hs, vs, act);
        rgb = 24'h0;
        if (act) begin
            ci = (cyc - 1) & 15;
            if (PATTERN_BUILT && tp_hist[ci]) rgb = bars(src % HT);
            else rgb = expand(rgb_hist[ci]);
        end
        check("pixelX", 32'(pixelX), cyc % HT);
        check("pixelY", 32'(pixelY), (cyc / HT) % VT);
        check("startOfFrame", 32'(startOfFrame), (cyc % FRAME == 0) ? 1 : 0);
        check("vgaHS", 32'(vgaHS), 32'(hs));
        check("vgaVS", 32'(vgaVS), 32'(vs));
        check("vgaBlankN", 32'(vgaBlankN), 32'(act));
        check("rgb", 32'({vgaR, vgaG, vgaB}), 32'(rgb));
        if (src >= 0) begin
            foreach (spots[i]) begin
                if (spots[i].x == src % HT && spots[i].y == (src / HT) % VT) begin
                    spot_hits++;
                    check("spot_rgb", 32'({vgaR, vgaG, vgaB}), 32'(spots[i].rgb));
                    check("spot_blank", 32'(vgaBlankN), 32'(spots[i].blank_n));
                end
            end
        end
        // Pulse widths and frame spacing measured straight off the pins.
        if (!vgaHS) hs_low++;
        else begin
            if (hs_low != 0) check("hs_width", hs_low, HS);
            hs_low = 0;
        end
        if (!vgaVS) vs_low++;
        else begin
            if (vs_low != 0) check("vs_width", vs_low, VS * HT);
            vs_low = 0;
        end
        if (vgaBlankN) blank_high++;
        else begin
            if (blank_high != 0) check("blank_width", blank_high, HV);
            blank_high = 0;
        end
        if (startOfFrame) begin
            if (last_sof >= 0) check("sof_spacing", cyc - last_sof, FRAME);
            last_sof = cyc;
        end
    endtask

    task automatic drive_inputs();
        case (mode)
            M_RAMP:  RGBIn = (cyc - PD >= 0) ? {2'b00, 6'((cyc - PD) % HT)} : 8'h00;
            M_CONST: RGBIn = const_val;
            default: RGBIn = 8'($urandom);
        endcase
        testPattern = tp_rand ? 1'($urandom) : tp_value;
        rgb_hist[cyc & 15] = RGBIn;
        tp_hist[cyc & 15]  = testPattern;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetN = 1'b1;
        cyc = -1;
        monitor_clear();
        drive_inputs();
    endtask

    task automatic run_until(input int end_cyc);
        while (cyc < end_cyc) begin
            @(negedge clk);
            cyc++;
            check_cycle();
            drive_inputs();
        end
    endtask

    task automatic add_spot(input int x, input int y, input logic [23:0] rgb, input logic blank_n);
        spot_t s;
        s.x = x; s.y = y; s.rgb = rgb; s.blank_n = blank_n;
        spots.push_back(s);
    endtask

    task automatic end_spots();
        check("spot_hits", spot_hits, spots.size());
        spots.delete();
        spot_hits = 0;
    endtask

    initial begin
        #(100000 * 40);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = -1;
        spot_hits = 0;
        monitor_clear();

        // Power-on reset with random colour on the bus.
        repeat (3) begin
            @(negedge clk);
            RGBIn = 8'($urandom);
            #1 check_reset_values();
        end

        // Ramp colour from a one-cycle drawer; pixel 37 of line 3 must show 92/B6/00.
        mode = M_RAMP;
        release_reset();
        add_spot(37, 3, 24'h92B600, 1'b1);
        run_until(4 * HT);
        end_spots();

        mode = M_CONST; const_val = 8'hFF;
        add_spot(10, 4, 24'hFFFFFF, 1'b1);
        add_spot(700, 4, 24'h000000, 1'b0);
        run_until(5 * HT);
        end_spots();

        const_val = 8'hC0;
        add_spot(200, 5, 24'h0000FF, 1'b1);
        run_until(6 * HT);
        end_spots();

        const_val = 8'h38;
        add_spot(300, 6, 24'hFF0000, 1'b1);
        run_until(7 * HT);
        end_spots();

        // Colour bars with RGBIn black: only the built pattern can light the pins.
        const_val = 8'h00; tp_value = 1'b1;
        add_spot(10, 7, 24'h000000, 1'b1);
        add_spot(100, 7, PATTERN_BUILT ? 24'h0000FF : 24'h000000, 1'b1);
        add_spot(480, 7, PATTERN_BUILT ? 24'hFFFFFF : 24'h000000, 1'b1);
        run_until(8 * HT);
        end_spots();

        // Random colour and pattern select across two frame wraps.
        mode = M_RANDOM; tp_value = 1'b0; tp_rand = 1'b1;
        run_until(2 * FRAME + 2000);

        // Mid-frame reset, asserted and released away from clock edges.
        @(negedge clk);
        #5 resetN = 1'b0;
        #1 check_reset_values();
        repeat (3) begin
            @(negedge clk);
            RGBIn = 8'($urandom);
            #1 check_reset_values();
        end
        release_reset();
        run_until(3 * HT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
